// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: opcodes, flag positions,
// the buffered entry layout and a parity helper.
// Optional feature macro: ALU_RES_PARITY_EN adds a parity bit to each entry.
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_OP_W   = 4;

  localparam logic [3:0] OP_NOT  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SHR  = 4'b0111;
  localparam logic [3:0] OP_SHL  = 4'b1000;
  localparam logic [3:0] OP_LAST = 4'b1000;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_I = 3;

  // One buffered result as it travels through the two-entry queue.
  typedef struct packed {
    logic [ALU_DATA_W-1:0] result;
    logic [ALU_OP_W-1:0]   op;
    logic [3:0]            flags;
`ifdef ALU_RES_PARITY_EN
    logic                  parity;
`endif
  } alu_entry_t;

  // Even-parity bit over a result word (XOR of all bits).
  function automatic logic calc_parity(input logic [ALU_DATA_W-1:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/alu_res_fifo2.sv
// Generic two-entry FIFO: a read pointer bit plus a 0..2 occupancy count.
// The write slot is derived from the read pointer and occupancy, so order
// is preserved across simultaneous push and pop. Callers qualify push/pop.
module alu_res_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             not_full,
  output logic             not_empty
);

  logic [WIDTH-1:0] mem0_r;
  logic [WIDTH-1:0] mem1_r;
  logic             rd_ptr_r;
  logic [1:0]       count_r;
  logic [1:0]       count_next_s;
  logic             wr_ptr_s;

  // With one entry held the free slot is the other one; otherwise it is rd_ptr.
  assign wr_ptr_s  = rd_ptr_r ^ count_r[0];
  assign rdata     = rd_ptr_r ? mem1_r : mem0_r;
  assign not_full  = (count_r != 2'd2);
  assign not_empty = (count_r != 2'd0);

  // Next occupancy from the push/pop combination.
  always_comb begin
    count_next_s = count_r;
    case ({push, pop})
      2'b10:   count_next_s = count_r + 2'd1;
      2'b01:   count_next_s = count_r - 2'd1;
      default: count_next_s = count_r;
    endcase
  end

  // Storage, read pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0_r   <= {WIDTH{1'b0}};
      mem1_r   <= {WIDTH{1'b0}};
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr_s) begin
          mem1_r <= wdata;
        end else begin
          mem0_r <= wdata;
        end
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_next_s;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage behind the 32-bit ALU. Derives {I,V,N,Z} flags at
// the input, buffers up to two results behind valid/ready, and keeps a
// transfer counter (wrapping) and an illegal-op counter (saturating).
// Optional feature macro: ALU_RES_PARITY_EN adds out_parity per entry.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W   = ALU_OP_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [OP_W-1:0]   in_op,
  input  logic              in_a_msb,
  input  logic              in_b_msb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [OP_W-1:0]   out_op,
  output logic [3:0]        out_flags,
`ifdef ALU_RES_PARITY_EN
  output logic              out_parity,
`endif
  output logic [CNT_W-1:0]  res_count,
  output logic [CNT_W-1:0]  illegal_count
);

  logic             push_s;
  logic             pop_s;
  logic             not_full_s;
  logic             not_empty_s;
  logic [3:0]       flags_s;
  alu_entry_t       wr_entry_s;
  alu_entry_t       rd_entry_s;
  logic [CNT_W-1:0] res_count_r;
  logic [CNT_W-1:0] illegal_count_r;

  assign in_ready  = not_full_s;
  assign out_valid = not_empty_s;
  assign push_s    = in_valid && not_full_s;
  assign pop_s     = not_empty_s && out_ready;

  // Status flags of the incoming result; overflow only for add and sub.
  always_comb begin
    flags_s         = 4'b0000;
    flags_s[FLAG_Z] = (in_result == {DATA_W{1'b0}});
    flags_s[FLAG_N] = in_result[DATA_W-1];
    case (in_op)
      OP_ADD:  flags_s[FLAG_V] = (in_a_msb == in_b_msb) && (in_result[DATA_W-1] != in_a_msb);
      OP_SUB:  flags_s[FLAG_V] = (in_a_msb != in_b_msb) && (in_result[DATA_W-1] != in_a_msb);
      default: flags_s[FLAG_V] = 1'b0;
    endcase
    flags_s[FLAG_I] = (in_op > OP_LAST);
  end

  // Pack the entry written into the queue on a push.
  always_comb begin
    wr_entry_s.result = in_result;
    wr_entry_s.op     = in_op;
    wr_entry_s.flags  = flags_s;
`ifdef ALU_RES_PARITY_EN
    wr_entry_s.parity = calc_parity(in_result);
`endif
  end

  alu_res_fifo2 #(
    .WIDTH ($bits(alu_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .wdata     (wr_entry_s),
    .pop       (pop_s),
    .rdata     (rd_entry_s),
    .not_full  (not_full_s),
    .not_empty (not_empty_s)
  );

  assign out_result = rd_entry_s.result;
  assign out_op     = rd_entry_s.op;
  assign out_flags  = rd_entry_s.flags;
`ifdef ALU_RES_PARITY_EN
  assign out_parity = rd_entry_s.parity;
`endif

  // Debug counters: transfers wrap, illegal ops stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_count_r     <= {CNT_W{1'b0}};
      illegal_count_r <= {CNT_W{1'b0}};
    end else begin
      if (pop_s) begin
        res_count_r <= res_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (push_s && flags_s[FLAG_I] && (illegal_count_r != {CNT_W{1'b1}})) begin
        illegal_count_r <= illegal_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign res_count     = res_count_r;
  assign illegal_count = illegal_count_r;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: stimulus computes the expected entry
// from operands with plain signed arithmetic; a negedge monitor tracks the
// accepted entries in a queue and compares every output transfer.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [3:0]  in_op;
  logic        in_a_msb;
  logic        in_b_msb;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_op;
  logic [3:0]  out_flags;
  logic [15:0] res_count;
  logic [15:0] illegal_count;
`ifdef ALU_RES_PARITY_EN
  logic        out_parity;
`endif

  always #5 clk = ~clk;

  alu_result_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_result     (in_result),
    .in_op         (in_op),
    .in_a_msb      (in_a_msb),
    .in_b_msb      (in_b_msb),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_op        (out_op),
    .out_flags     (out_flags),
`ifdef ALU_RES_PARITY_EN
    .out_parity    (out_parity),
`endif
    .res_count     (res_count),
    .illegal_count (illegal_count)
  );

  typedef struct {
    logic [31:0] result;
    logic [3:0]  op;
    logic [3:0]  flags;
    logic        parity;
  } exp_t;

  exp_t        sb[$];
  exp_t        exp_pending;
  exp_t        mon_e;
  int          checks = 0;
  int          passes = 0;
  logic [15:0] m_res = 16'd0;
  logic [15:0] m_ill = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // What the ALU itself produces for an opcode (illegal ops give 0).
  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return ~a;
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a * b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a ^ b;
      4'd7:    return a >> 1;
      4'd8:    return a << 1;
      default: return 32'd0;
    endcase
  endfunction

  // Expected entry: overflow judged by exact signed arithmetic on full operands.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] r);
    exp_t   e;
    longint s;
    e.result = r;
    e.op     = op;
    e.parity = ^r;
    e.flags  = 4'b0000;
    e.flags[0] = (r == 32'd0);
    e.flags[1] = r[31];
    s = 0;
    if (op == 4'd1) s = longint'($signed(a)) + longint'($signed(b));
    if (op == 4'd2) s = longint'($signed(a)) - longint'($signed(b));
    e.flags[2] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    e.flags[3] = (op > 4'd8);
    return e;
  endfunction

  task automatic step(input logic v, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] r, input logic ordy);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_op     = op;
    in_result = r;
    in_a_msb  = a[31];
    in_b_msb  = b[31];
    out_ready = ordy;
    if (v) exp_pending = model(op, a, b, r);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, ordy);
  endtask

  // Monitor: occupancy/counter checks every cycle, compare on each transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, sb.size() != 2});
      chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
      chk("res_count", {16'd0, res_count}, {16'd0, m_res});
      chk("illegal_count", {16'd0, illegal_count}, {16'd0, m_ill});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL pop_empty: got transfer expected none");
        end else begin
          mon_e = sb.pop_front();
          chk("out_result", out_result, mon_e.result);
          chk("out_op", {28'd0, out_op}, {28'd0, mon_e.op});
          chk("out_flags", {28'd0, out_flags}, {28'd0, mon_e.flags});
`ifdef ALU_RES_PARITY_EN
          chk("out_parity", {31'd0, out_parity}, {31'd0, mon_e.parity});
`endif
        end
        m_res = m_res + 16'd1;
      end
      if (in_valid && in_ready) begin
        sb.push_back(exp_pending);
        if (exp_pending.flags[3] && (m_ill != 16'hFFFF)) m_ill = m_ill + 16'd1;
      end
    end
  end

  initial begin
    logic        held;
    logic        v;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] base;
    bit          got;

    rst_n = 1'b0; in_valid = 1'b0; in_result = 32'd0; in_op = 4'd0;
    in_a_msb = 1'b0; in_b_msb = 1'b0; out_ready = 1'b0;
    exp_pending = model(4'd0, 32'd0, 32'd0, 32'd0);
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_op_flags", {24'd0, out_op, out_flags}, 32'd0);
    chk("rst_counters", {res_count, illegal_count}, 32'd0);
    #1 rst_n = 1'b1;

    // ADD overflow into the sign bit.
    step(1'b1, 4'd1, 32'h4000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0);
    @(negedge clk); @(negedge clk);
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_flags", {28'd0, out_flags}, 32'h6);
    idle(1'b1); idle(1'b1);
    @(negedge clk);
    chk("add_res_count", {16'd0, res_count}, 32'd1);

    // SUB giving zero with both operands negative.
    step(1'b1, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0);
    @(negedge clk); @(negedge clk);
    chk("sub_flags", {28'd0, out_flags}, 32'h1);
    idle(1'b1); idle(1'b1);

    // Illegal opcode.
    step(1'b1, 4'b1011, 32'h1234_5678, 32'h0, 32'd0, 1'b0);
    @(negedge clk); @(negedge clk);
    chk("ill_flags", {28'd0, out_flags}, 32'h9);
    chk("ill_count", {16'd0, illegal_count}, 32'd1);
    idle(1'b1); idle(1'b1);

    // Parity-relevant value (OR giving 7).
    step(1'b1, 4'd5, 32'd7, 32'd0, 32'd7, 1'b1);
    idle(1'b1); idle(1'b1);

    // Fill to two with the consumer stalled, hold a third until accepted.
    step(1'b1, 4'd4, 32'hF0F0_1111, 32'h0FF0_0001, alu(4'd4, 32'hF0F0_1111, 32'h0FF0_0001), 1'b0);
    step(1'b1, 4'd6, 32'hAAAA_0000, 32'h5555_0000, alu(4'd6, 32'hAAAA_0000, 32'h5555_0000), 1'b0);
    step(1'b1, 4'd7, 32'h8000_0002, 32'd0, alu(4'd7, 32'h8000_0002, 32'd0), 1'b0);
    @(negedge clk);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    step(1'b1, 4'd7, 32'h8000_0002, 32'd0, alu(4'd7, 32'h8000_0002, 32'd0), 1'b1);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step(1'b1, 4'd7, 32'h8000_0002, 32'd0, alu(4'd7, 32'h8000_0002, 32'd0), 1'b1);
      @(negedge clk);
      got = in_ready;
    end
    if (!got) begin
      checks++;
      $display("FAIL third_accept: got in_ready stuck 0 expected 1");
    end
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Streaming: 100 back-to-back pushes with the consumer always ready.
    base = m_res;
    for (int i = 0; i < 100; i++) begin
      op = 4'($urandom_range(0, 8)); a = $urandom; b = $urandom;
      step(1'b1, op, a, b, alu(op, a, b), 1'b1);
    end
    idle(1'b1); idle(1'b1);
    @(negedge clk);
    chk("stream_res_count", {16'd0, res_count}, {16'd0, base + 16'd100});

    // Random valid/ready traffic; stalled inputs are held until accepted.
    held = 1'b0; v = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
    for (int i = 0; i < 600; i++) begin
      if (!held) begin
        v  = ($urandom_range(0, 3) != 0);
        op = 4'($urandom_range(0, 15));
        a  = ($urandom_range(0, 4) == 0) ? 32'h7FFF_FFFF : $urandom;
        b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      end
      step(v, op, a, b, alu(op, a, b), ($urandom_range(0, 9) < 6));
      @(negedge clk);
      held = in_valid && !in_ready;
    end
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Asynchronous reset with two entries buffered.
    step(1'b1, 4'd1, 32'd1, 32'd2, 32'd3, 1'b0);
    step(1'b1, 4'd9, 32'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk); @(negedge clk);
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_counters", {res_count, illegal_count}, 32'd0);
    sb.delete();
    m_res = 16'd0;
    m_ill = 16'd0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Saturate the illegal-op counter.
    for (int i = 0; i < 65540; i++) begin
      op = 4'($urandom_range(9, 15));
      step(1'b1, op, $urandom, $urandom, 32'd0, 1'b1);
    end
    idle(1'b1); idle(1'b1); idle(1'b1);
    @(negedge clk);
    chk("ill_saturated", {16'd0, illegal_count}, 32'h0000_FFFF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
